// File: rtl/mul_iter_unit_pkg.sv
// Shared types and ALU-control decode for the iterative RV32M multiplier.
package mul_iter_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_MUL    = 4'b1000;
   localparam logic [3:0] ALU_MULH   = 4'b1001;
   localparam logic [3:0] ALU_MULHSU = 4'b1010;
   localparam logic [3:0] ALU_MULHU  = 4'b1011;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mul_state_t;
   typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} mul_op_t;

   function automatic logic is_mul(input logic [3:0] code);
      return (code == ALU_MUL) || (code == ALU_MULH) ||
             (code == ALU_MULHSU) || (code == ALU_MULHU);
   endfunction

   function automatic mul_op_t decode_op(input logic [3:0] code);
      case (code)
         ALU_MULH:   return OP_MULH;
         ALU_MULHSU: return OP_MULHSU;
         ALU_MULHU:  return OP_MULHU;
         default:    return OP_MUL;
      endcase
   endfunction

endpackage

// File: rtl/mul_iter_step.sv
// One shift-add iteration: retires BITS_PER_CYCLE multiplier bits from the low end of acc.
module mul_iter_step #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [2*XLEN-1:0]         acc_i,
   input  logic [XLEN-1:0]           mcand_i,
   input  logic [BITS_PER_CYCLE-1:0] mbits_i,
   output logic [2*XLEN-1:0]         acc_o
);

   logic [2*XLEN:0] t;

   // Extra top bit catches the carry of the high-half add before the shift.
   always_comb begin
      t = {1'b0, acc_i};
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (mbits_i[i]) begin
            t[2*XLEN:XLEN] = {1'b0, t[2*XLEN-1:XLEN]} + {1'b0, mcand_i};
         end
         t = t >> 1;
      end
      acc_o = t[2*XLEN-1:0];
   end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative multiplier for MUL/MULH/MULHSU/MULHU; stalls EX while computing.
//  state | meaning
//  IDLE  | waiting for an accepted MUL* instruction
//  CALC  | shift-add of operand magnitudes, N cycles
//  FIX   | apply result sign, load result register
//  DONE  | done_o pulse, instruction leaves EX
module mul_iter_unit #(
   parameter int XLEN           = mul_iter_unit_pkg::XLEN,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [3:0]      alu_ctrl_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   import mul_iter_unit_pkg::*;

   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   mul_state_t        state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   mul_op_t           op_q, op_d;
   logic              neg_q, neg_d;
   logic              done_q, done_d;

   mul_op_t           op_in;
   logic              rs1_sgn, rs2_sgn, accept;
   logic [XLEN-1:0]   rs1_mag, rs2_mag;
   logic [2*XLEN-1:0] acc_step, acc_fix;

   always_comb begin
      op_in   = decode_op(alu_ctrl_i);
      rs1_sgn = (op_in == OP_MULH) || (op_in == OP_MULHSU);
      rs2_sgn = (op_in == OP_MULH);
      rs1_mag = (rs1_sgn && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
      rs2_mag = (rs2_sgn && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
      accept  = (state_q == IDLE) && start_i && is_mul(alu_ctrl_i) && !flush_i;
      acc_fix = neg_q ? -acc_q : acc_q;
   end

   // The multiplier lives in the low half of acc and shifts out as partial products enter.
   mul_iter_step #(
      .XLEN           (XLEN),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .acc_i   (acc_q),
      .mcand_i (mcand_q),
      .mbits_i (acc_q[BITS_PER_CYCLE-1:0]),
      .acc_o   (acc_step)
   );

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      op_d     = op_q;
      neg_d    = neg_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               mcand_d = rs1_mag;
               acc_d   = {{XLEN{1'b0}}, rs2_mag};
               op_d    = op_in;
               neg_d   = (rs1_sgn & rs1_i[XLEN-1]) ^ (rs2_sgn & rs2_i[XLEN-1]);
               count_d = CW'(N);
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d   = acc_step;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = FIX;
         end
         FIX: begin
            acc_d    = acc_fix;
            result_d = (op_q == OP_MUL) ? acc_fix[XLEN-1:0] : acc_fix[2*XLEN-1:XLEN];
            done_d   = 1'b1;
            state_d  = DONE;
         end
         default: state_d = IDLE;
      endcase
      // In DONE the pulse and result are already out, so a flush there changes nothing visible.
      if (flush_i) begin
         state_d  = IDLE;
         done_d   = 1'b0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         op_q     <= OP_MUL;
         neg_q    <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign stall_o  = accept || (state_q == CALC) || (state_q == FIX);
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Scoreboard bench for mul_iter_unit at 1 and 4 bits per cycle.
module tb_mul_iter_unit;
   import mul_iter_unit_pkg::*;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   logic        clk, rst_n, start, start4, flush;
   logic [3:0]  alu;
   logic [31:0] rs1, rs2;
   logic        stall, done, stall4, done4;
   logic [31:0] result, result4;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t q1[$];
   exp_t q4[$];

   mul_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(start), .alu_ctrl_i(alu),
      .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush),
      .stall_o(stall), .done_o(done), .result_o(result)
   );

   mul_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start_i(start4), .alu_ctrl_i(alu),
      .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush),
      .stall_o(stall4), .done_o(done4), .result_o(result4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always begin : mon1
      exp_t e;
      @(negedge clk);
      #2;
      if (done) begin
         if (q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done1: got result %h want no done (cycle %0d)", result, cyc);
         end else begin
            e = q1.pop_front();
            chk("result1", result, e.res);
            chk("done_cycle1", cyc, e.cyc);
         end
      end
   end

   always begin : mon4
      exp_t e;
      @(negedge clk);
      #2;
      if (done4) begin
         if (q4.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done4: got result %h want no done (cycle %0d)", result4, cyc);
         end else begin
            e = q4.pop_front();
            chk("result4", result4, e.res);
            chk("done_cycle4", cyc, e.cyc);
         end
      end
   end

   // Issue one op, hold start through the stall window and check stall every cycle.
   task automatic do_op(input bit sel4, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit scr);
      int   n;
      int   c0;
      exp_t e;
      n = sel4 ? 8 : 32;
      @(negedge clk);
      if (sel4) start4 = 1'b1; else start = 1'b1;
      alu = op;
      rs1 = a;
      rs2 = b;
      #1;
      c0    = cyc;
      e.res = exp;
      e.cyc = c0 + n + 2;
      if (sel4) q4.push_back(e); else q1.push_back(e);
      for (int k = 0; k <= n + 2; k++) begin
         if (k > 0) begin
            @(negedge clk);
            if (scr) begin
               rs1 = $urandom;
               rs2 = $urandom;
            end
            #1;
         end
         chk(sel4 ? "stall4" : "stall1", sel4 ? stall4 : stall, (k <= n + 1) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      start  = 1'b0;
      start4 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      start4 = 1'b0;
      flush  = 1'b0;
      alu    = ALU_ADD;
      rs1    = '0;
      rs2    = '0;
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, 32'h0);
      chk("rst_result4", result4, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_op(0, ALU_MUL,    32'd7,        32'd6,        32'd42,       0);
      do_op(0, ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0);
      do_op(0, ALU_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 0);
      do_op(0, ALU_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, 0);
      do_op(0, ALU_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 0);
      do_op(0, ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      do_op(0, ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
      do_op(0, ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0);
      do_op(0, ALU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);

      // Flush in cycle 10 of MUL 3*5 while start is still high.
      @(negedge clk);
      start = 1'b1;
      alu   = ALU_MUL;
      rs1   = 32'd3;
      rs2   = 32'd5;
      for (int k = 1; k <= 10; k++) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      start = 1'b0;
      #1;
      chk("flush_stall", stall, 1'b0);
      chk("flush_done", done, 1'b0);
      chk("flush_result_kept", result, 32'h1);
      do_op(0, ALU_MUL, 32'd3, 32'd5, 32'd15, 0);

      // Async reset in cycle 20 of a MULH.
      @(negedge clk);
      start = 1'b1;
      alu   = ALU_MULH;
      rs1   = 32'h80000000;
      rs2   = 32'd3;
      for (int k = 1; k <= 20; k++) @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      chk("arst_stall", stall, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_result", result, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_stall", stall, 1'b0);
      do_op(0, ALU_MUL, 32'd2, 32'd2, 32'd4, 0);

      // Non-MUL code and flush-beats-start in IDLE must not start work.
      @(negedge clk);
      start = 1'b1;
      alu   = ALU_ADD;
      rs1   = 32'd9;
      rs2   = 32'd9;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk("add_stall", stall, 1'b0);
      end
      @(negedge clk);
      alu   = ALU_MUL;
      flush = 1'b1;
      #1;
      chk("flush_idle_stall", stall, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      start = 1'b0;
      #1;
      chk("flush_idle_after", stall, 1'b0);
      repeat (40) @(negedge clk);

      // Operand churn after accept must not matter.
      do_op(0, ALU_MULHU, 32'hFFFF0000, 32'h00010000, 32'h0000FFFF, 1);
      do_op(0, ALU_MUL,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1);

      do_op(1, ALU_MUL,    32'd7,        32'd6,        32'd42,       0);
      do_op(1, ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0);
      do_op(1, ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);

      repeat (5) @(negedge clk);
      #3;
      chk("q1_drained", q1.size(), 32'd0);
      chk("q4_drained", q4.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
